// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor: a WIDTH-bit operand pair is
// summed CHUNK bits per clock through one ripple stage, with valid/ready on both sides.
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;

    int               idx;
    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic             chunk_carry;
    logic             msb_carry_in;

    always_comb begin
        idx          = int'(cnt_q) * CHUNK;
        a_chunk      = a_q[idx +: CHUNK];
        b_chunk      = b_q[idx +: CHUNK];
        {chunk_carry, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk}
                                 + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit of this chunk, recovered from its sum bit.
        msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum_chunk[CHUNK-1];

        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        negative_d  = negative_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    carry_d = Cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[idx +: CHUNK] = sum_chunk;
                carry_d = chunk_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    carry_out_d = chunk_carry;
                    overflow_d  = chunk_carry ^ msb_carry_in;
                    zero_d      = (result_d == '0);
                    negative_d  = result_d[WIDTH-1];
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Result    = result_q;
    assign CarryOut  = carry_out_q;
    assign Overflow  = overflow_q;
    assign Zero      = zero_q;
    assign Negative  = negative_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq (WIDTH=16, CHUNK=4): arithmetic vectors, flags,
// latency, backpressure, ignored in_valid and asynchronous reset abort.
module tb_addsub_seq;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Sub;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             CarryOut;
    logic             Overflow;
    logic             Zero;
    logic             Negative;

    int checks = 0;
    int errors = 0;

    addsub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Sub       (Sub),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .CarryOut  (CarryOut),
        .Overflow  (Overflow),
        .Zero      (Zero),
        .Negative  (Negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one command for one accepting edge, then wait (bounded) for out_valid.
    // lat returns the number of edges after the accepting edge, or -1 on timeout.
    // With noise set, in_valid stays high with junk operands while the op is busy.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub, input logic cin, input bit noise,
                                 output int lat);
        A        = a;
        B        = b;
        Sub      = sub;
        Cin      = cin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = noise;
        A        = 16'hFFFF;
        B        = 16'hFFFF;
        Sub      = 1'b0;
        Cin      = 1'b1;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A = '0; B = '0; Sub = 1'b0; Cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, Result, CarryOut, Overflow, Zero, Negative} !== {2'b10, 16'h0000, 4'b0000}) begin
            errors++;
            $display("[TB] FAIL reset_state: got rdy=%b vld=%b res=%h flags=%b%b%b%b expected rdy=1 vld=0 res=0000 flags=0000",
                     in_ready, out_valid, Result, CarryOut, Overflow, Zero, Negative);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL idle_after_release: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic             cin;
        logic [WIDTH-1:0] res;
        logic [3:0]       flags;  // {CarryOut, Overflow, Zero, Negative}
    } vec_t;

    // Hand-computed vectors; the last pair is a borrow chain (Cin=0 then Cin=1).
    task automatic test_arith();
        vec_t vecs[7];
        int   lat;
        vecs[0] = '{16'h1234, 16'h0034, 1'b1, 1'b1, 16'h1200, 4'b1000};
        vecs[1] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 4'b0001};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b0101};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b1010};
        vecs[4] = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 4'b0000};
        vecs[5] = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'hFFFF, 4'b0001};
        vecs[6] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 4'b1100};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, 1'b0, lat);
            checks++;
            if (lat !== N) begin
                errors++;
                $display("[TB] FAIL latency_%0d: got %0d expected %0d", i, lat, N);
            end
            checks++;
            if ({Result, CarryOut, Overflow, Zero, Negative} !== {vecs[i].res, vecs[i].flags}) begin
                errors++;
                $display("[TB] FAIL arith_%0d: got res=%h cvzn=%b%b%b%b expected res=%h cvzn=%b",
                         i, Result, CarryOut, Overflow, Zero, Negative, vecs[i].res, vecs[i].flags);
            end
            handshake();
            checks++;
            if ({in_ready, out_valid, Result, CarryOut, Overflow, Zero, Negative} !== {2'b10, vecs[i].res, vecs[i].flags}) begin
                errors++;
                $display("[TB] FAIL after_handshake_%0d: got rdy=%b vld=%b res=%h expected rdy=1 vld=0 res=%h (held)",
                         i, in_ready, out_valid, Result, vecs[i].res);
            end
        end
    endtask

    // Hold DONE for 10 cycles with in_valid asserted the whole time.
    task automatic test_backpressure();
        int lat;
        int bad;
        applyStimulus(16'h1234, 16'h0034, 1'b1, 1'b1, 1'b1, lat);
        checks++;
        if (lat !== N) begin
            errors++;
            $display("[TB] FAIL bp_latency: got %0d expected %0d", lat, N);
        end
        in_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if ({out_valid, in_ready, Result, CarryOut, Overflow, Zero, Negative} !== {2'b10, 16'h1200, 4'b1000}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL bp_hold: got %0d unstable cycles, last res=%h vld=%b expected 0 unstable, res=1200 vld=1",
                     bad, Result, out_valid);
        end
        in_valid = 1'b0;
        handshake();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL bp_release: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    // Next command accepted right after the handshake, so issue interval is N+2.
    task automatic test_back_to_back();
        int lat;
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, lat);
        handshake();
        applyStimulus(16'h0100, 16'h0100, 1'b1, 1'b1, 1'b0, lat);
        checks++;
        if ({lat == N, Result, CarryOut, Overflow, Zero, Negative} !== {1'b1, 16'h0000, 4'b1010}) begin
            errors++;
            $display("[TB] FAIL back_to_back: got lat=%0d res=%h cvzn=%b%b%b%b expected lat=%0d res=0000 cvzn=1010",
                     lat, Result, CarryOut, Overflow, Zero, Negative, N);
        end
        handshake();
    endtask

    task automatic test_reset_abort();
        int lat;
        // Abort in DONE: out_valid must fall with no clock edge.
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, lat);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, Result, CarryOut, Overflow, Zero, Negative} !== {2'b10, 16'h0000, 4'b0000}) begin
            errors++;
            $display("[TB] FAIL abort_done: got rdy=%b vld=%b res=%h flags=%b%b%b%b expected rdy=1 vld=0 res=0000 flags=0000",
                     in_ready, out_valid, Result, CarryOut, Overflow, Zero, Negative);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Abort at the 2nd RUN cycle.
        A = 16'h1234; B = 16'h0034; Sub = 1'b1; Cin = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, Result, CarryOut, Overflow, Zero, Negative} !== {2'b10, 16'h0000, 4'b0000}) begin
            errors++;
            $display("[TB] FAIL abort_run: got rdy=%b vld=%b res=%h expected rdy=1 vld=0 res=0000",
                     in_ready, out_valid, Result);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL abort_release: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
        applyStimulus(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, lat);
        checks++;
        if ({lat == N, Result, CarryOut, Overflow, Zero, Negative} !== {1'b1, 16'h0007, 4'b0000}) begin
            errors++;
            $display("[TB] FAIL post_abort_op: got lat=%0d res=%h cvzn=%b%b%b%b expected lat=%0d res=0007 cvzn=0000",
                     lat, Result, CarryOut, Overflow, Zero, Negative, N);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
